// File: rtl/uart8.sv
// 8N1 UART: 16x-oversampled receiver with false-start rejection and framing check,
// plus a one-byte-per-request transmitter; both run from a single clock.
module uart8 #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxEn,
  input  logic       rxIn,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] rxOut,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] txIn,
  output logic       txBusy,
  output logic       txDone,
  output logic       txOut
);

  localparam int RX_DIV = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int RXW    = $clog2(RX_DIV + 1);
  localparam int TXW    = $clog2(TX_DIV + 1);
  localparam logic [RXW-1:0] RX_LAST = RXW'(RX_DIV - 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(TX_DIV - 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rxState_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } txState_t;

  // ---------------- receiver ----------------
  logic           rxMeta;
  logic           rxSync;
  logic [RXW-1:0] tickCnt;
  logic           tick;
  rxState_t       rxState;
  logic [3:0]     sampleCnt;
  logic [2:0]     rxBitCnt;
  logic [7:0]     rxShift;

  assign tick = (tickCnt == RX_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= rxIn;
      rxSync <= rxMeta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || tick) begin
      tickCnt <= '0;
    end else begin
      tickCnt <= tickCnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rxState   <= RX_IDLE;
      sampleCnt <= '0;
      rxBitCnt  <= '0;
      rxShift   <= '0;
      rxBusy    <= 1'b0;
      rxDone    <= 1'b0;
      rxErr     <= 1'b0;
      rxOut     <= 8'h00;
    end else begin
      rxDone <= 1'b0;
      rxErr  <= 1'b0;
      if (!rxEn) begin
        rxState   <= RX_IDLE;
        rxBusy    <= 1'b0;
        sampleCnt <= '0;
        rxBitCnt  <= '0;
      end else if (tick) begin
        case (rxState)
          RX_IDLE: begin
            if (!rxSync) begin
              rxState   <= RX_START;
              sampleCnt <= '0;
            end
          end
          RX_START: begin
            // Mid-start-bit recheck: a line back high here was only a glitch.
            if (sampleCnt == 4'd7) begin
              sampleCnt <= '0;
              if (rxSync) begin
                rxState <= RX_IDLE;
              end else begin
                rxState  <= RX_DATA;
                rxBusy   <= 1'b1;
                rxBitCnt <= '0;
              end
            end else begin
              sampleCnt <= sampleCnt + 1'b1;
            end
          end
          RX_DATA: begin
            if (sampleCnt == 4'd15) begin
              sampleCnt <= '0;
              rxShift   <= {rxSync, rxShift[7:1]};
              rxBitCnt  <= rxBitCnt + 1'b1;
              if (rxBitCnt == 3'd7) begin
                rxState <= RX_STOP;
              end
            end else begin
              sampleCnt <= sampleCnt + 1'b1;
            end
          end
          RX_STOP: begin
            if (sampleCnt == 4'd15) begin
              sampleCnt <= '0;
              rxBusy    <= 1'b0;
              if (rxSync) begin
                rxOut   <= rxShift;
                rxDone  <= 1'b1;
                rxState <= RX_IDLE;
              end else begin
                rxErr   <= 1'b1;
                rxState <= RX_WAIT_HIGH;
              end
            end else begin
              sampleCnt <= sampleCnt + 1'b1;
            end
          end
          RX_WAIT_HIGH: begin
            // A break (line held low) must not look like a stream of start bits.
            if (rxSync) begin
              rxState <= RX_IDLE;
            end
          end
          default: begin
            rxState <= RX_IDLE;
            rxBusy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------- transmitter ----------------
  txState_t       txState;
  logic [TXW-1:0] txTimer;
  logic [2:0]     txBitCnt;
  logic [7:0]     txShift;
  logic           bitEnd;

  assign bitEnd = (txTimer == TX_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      txState  <= TX_IDLE;
      txTimer  <= '0;
      txBitCnt <= '0;
      txShift  <= '0;
      txBusy   <= 1'b0;
      txDone   <= 1'b0;
      txOut    <= 1'b1;
    end else begin
      txDone <= 1'b0;
      if (!txEn) begin
        txState <= TX_IDLE;
        txTimer <= '0;
        txBusy  <= 1'b0;
        txOut   <= 1'b1;
      end else begin
        if (txState == TX_IDLE || bitEnd) begin
          txTimer <= '0;
        end else begin
          txTimer <= txTimer + 1'b1;
        end
        case (txState)
          TX_IDLE: begin
            if (txStart) begin
              txShift  <= txIn;
              txBusy   <= 1'b1;
              txOut    <= 1'b0;
              txBitCnt <= '0;
              txState  <= TX_START;
            end
          end
          TX_START: begin
            if (bitEnd) begin
              txOut   <= txShift[0];
              txState <= TX_DATA;
            end
          end
          TX_DATA: begin
            if (bitEnd) begin
              if (txBitCnt == 3'd7) begin
                txOut   <= 1'b1;
                txState <= TX_STOP;
              end else begin
                txOut    <= txShift[1];
                txShift  <= {1'b0, txShift[7:1]};
                txBitCnt <= txBitCnt + 1'b1;
              end
            end
          end
          TX_STOP: begin
            if (bitEnd) begin
              txBusy  <= 1'b0;
              txDone  <= 1'b1;
              txState <= TX_IDLE;
            end
          end
          default: begin
            txState <= TX_IDLE;
            txBusy  <= 1'b0;
            txOut   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart8.sv
// Scoreboarded bench for uart8: bytes expected at rxOut are queued as frames are driven.
`timescale 1ns/1ps
module tb_uart8;

  localparam real BIT_NS  = 104166.7;
  localparam real SLOW_NS = 107500.0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxEn = 1'b1;
  logic       rxDrv = 1'b1;
  logic       loop = 1'b0;
  logic       rxIn;
  logic       rxBusy, rxDone, rxErr;
  logic [7:0] rxOut;
  logic       txEn = 1'b1;
  logic       txStart = 1'b0;
  logic [7:0] txIn = 8'h00;
  logic       txBusy, txDone, txOut;

  int checks = 0;
  int errors = 0;
  int doneCnt = 0;
  int errCnt = 0;
  logic busySeen = 1'b0;
  logic prevDone = 1'b0;
  logic [7:0] expQ[$];

  assign rxIn = loop ? txOut : rxDrv;

  always #41.667 clk = ~clk;

  uart8 #(.CLOCK_RATE(12000000), .BAUD_RATE(9600)) dut (
    .clk(clk), .reset(reset),
    .rxEn(rxEn), .rxIn(rxIn), .rxBusy(rxBusy), .rxDone(rxDone), .rxErr(rxErr), .rxOut(rxOut),
    .txEn(txEn), .txStart(txStart), .txIn(txIn), .txBusy(txBusy), .txDone(txDone), .txOut(txOut)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop on every rxDone, pulse-shape checks.
  always @(negedge clk) begin
    if (rxBusy === 1'b1) busySeen = 1'b1;
    if (rxDone === 1'b1 || rxErr === 1'b1) chk("doneErrExcl", {31'd0, rxDone & rxErr}, 32'd0);
    if (rxDone === 1'b1) begin
      chk("donePulse", {31'd0, prevDone}, 32'd0);
      doneCnt++;
      if (expQ.size() == 0) chk("unexpectedDone", {24'd0, rxOut}, 32'hFFFF_FFFF);
      else chk("rxOut", {24'd0, rxOut}, {24'd0, expQ.pop_front()});
    end
    if (rxErr === 1'b1) errCnt++;
    prevDone = (rxDone === 1'b1);
  end

  task automatic sendFrame(input logic [7:0] b, input real bitNs, input logic stopBit);
    rxDrv = 1'b0;
    #(bitNs);
    for (int i = 0; i < 8; i++) begin
      rxDrv = b[i];
      #(bitNs);
    end
    rxDrv = stopBit;
    #(bitNs);
  endtask

  task automatic waitDone(input string tag, input int target, input int maxCycles);
    int n = 0;
    while (doneCnt < target && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    chk(tag, doneCnt, target);
  endtask

  initial begin
    int d0;
    int e0;
    int len;

    repeat (4) @(negedge clk);
    chk("rstRxBusy", {31'd0, rxBusy}, 32'd0);
    chk("rstRxDone", {31'd0, rxDone}, 32'd0);
    chk("rstRxErr", {31'd0, rxErr}, 32'd0);
    chk("rstRxOut", {24'd0, rxOut}, 32'h00);
    chk("rstTxBusy", {31'd0, txBusy}, 32'd0);
    chk("rstTxOut", {31'd0, txOut}, 32'd1);
    reset = 1'b1;
    repeat (200) @(negedge clk);

    // 16us glitch must be rejected at the start-bit recheck.
    busySeen = 1'b0;
    rxDrv = 1'b0;
    #16000;
    rxDrv = 1'b1;
    #(BIT_NS * 2);
    chk("glitchBusy", {31'd0, busySeen}, 32'd0);
    chk("glitchDone", doneCnt, 0);
    chk("glitchErr", errCnt, 0);

    // Nominal frame.
    busySeen = 1'b0;
    expQ.push_back(8'hD6);
    sendFrame(8'hD6, BIT_NS, 1'b1);
    #(BIT_NS);
    chk("d6BusySeen", {31'd0, busySeen}, 32'd1);
    waitDone("d6Done", 1, 100);
    chk("d6Err", errCnt, 0);

    // +3% slow bit period.
    expQ.push_back(8'hD6);
    sendFrame(8'hD6, SLOW_NS, 1'b1);
    #(BIT_NS);
    waitDone("slowDone", 2, 100);
    chk("slowErr", errCnt, 0);

    // rxEn dropped mid-frame: busy falls next clock, partial byte discarded.
    fork
      sendFrame(8'hD6, BIT_NS, 1'b1);
      begin
        #(BIT_NS * 4.5);
        @(negedge clk);
        chk("enBusyBefore", {31'd0, rxBusy}, 32'd1);
        rxEn = 1'b0;
        @(negedge clk);
        chk("enBusyAfter", {31'd0, rxBusy}, 32'd0);
      end
    join
    #(BIT_NS);
    rxEn = 1'b1;
    #(BIT_NS);
    chk("enNoDone", doneCnt, 2);
    chk("enRxOutKept", {24'd0, rxOut}, 32'hD6);

    // Framing error, line held low afterwards, then a good frame.
    e0 = errCnt;
    sendFrame(8'h3C, BIT_NS, 1'b0);
    #(BIT_NS * 3);
    chk("ferrPulse", errCnt, e0 + 1);
    chk("ferrNoDone", doneCnt, 2);
    chk("ferrRxOut", {24'd0, rxOut}, 32'hD6);
    chk("ferrBusy", {31'd0, rxBusy}, 32'd0);
    rxDrv = 1'b1;
    #(BIT_NS);
    expQ.push_back(8'h5A);
    sendFrame(8'h5A, BIT_NS, 1'b1);
    #(BIT_NS);
    waitDone("after5A", 3, 100);
    chk("ferrErrTotal", errCnt, e0 + 1);

    // Reset mid-frame, held until the line is idle again.
    fork
      sendFrame(8'hD6, BIT_NS, 1'b1);
      begin
        #(BIT_NS * 5.5);
        @(negedge clk);
        chk("rstBusyBefore", {31'd0, rxBusy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("rstBusyAfter", {31'd0, rxBusy}, 32'd0);
        chk("rstRxOutMid", {24'd0, rxOut}, 32'h00);
      end
    join
    #(BIT_NS);
    @(negedge clk);
    reset = 1'b1;
    #(BIT_NS);
    chk("rstNoDone", doneCnt, 3);

    // Loopback: transmitter drives the receiver.
    loop = 1'b1;
    d0 = doneCnt;
    expQ.push_back(8'hA5);
    @(negedge clk);
    txIn = 8'hA5;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    txIn = 8'h00;
    len = 0;
    for (int i = 0; i < 20000 && txDone !== 1'b1; i++) begin
      if (txBusy === 1'b1) len++;
      @(negedge clk);
    end
    chk("txDone", {31'd0, txDone}, 32'd1);
    chk("txBusyLen", len, 12500);
    @(negedge clk);
    chk("txDonePulse", {31'd0, txDone}, 32'd0);
    chk("txIdleOut", {31'd0, txOut}, 32'd1);
    waitDone("loopDone", d0 + 1, 2000);
    chk("loopRxOut", {24'd0, rxOut}, 32'hA5);

    chk("queueEmpty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
